vga_window_compositor: RTL
==========================

Name: vga_window_compositor

Overview:
- Parametrised successor of the single-window VGA overlay.
- Composites three layers onto the VGA pixel stream: a static text band, a camera window whose geometry can be changed at run time, and a background.
- Generates downscaled camera-buffer read addresses; the buffer answers with a fixed one-clock read latency.
- Window geometry is double-buffered and applied only at frame start, so the window never tears mid-frame.

Parameters:
- COLOR_W, 10, bits per colour channel
- COORD_W, 11, width of pixel coordinates and geometry inputs
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- TEXT_Y0, 10, first line of the text band
- TEXT_HEIGHT, 40, text band height in lines
- DEF_WIN_X0 / DEF_WIN_Y0, 80 / 70, window origin after reset
- DEF_WIN_W / DEF_WIN_H, 480 / 360, window size after reset
- SCALE_SHIFT, 1, camera address = window offset << SCALE_SHIFT
- TEXT_COLOR, all ones, text band colour (all channels)
- BG_COLOR, 0, background and blanking colour
- BLINK_FRAMES, 30, frames per blink half-period (optional feature only)

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  synchronous reset, active-high
- iFrame_Start  in  1  one-cycle pulse coincident with pixel (0,0)
- iPix_Valid  in  1  active-display qualifier for iVga_x/iVga_y
- iVga_x, iVga_y  in  COORD_W  current pixel coordinate
- iVideo_On  in  1  camera layer enable
- iWin_X0, iWin_Y0, iWin_W, iWin_H  in  COORD_W  requested window geometry
- iCfg_Load  in  1  pulse: capture requested geometry into the pending set
- iRed, iGreen, iBlue  in  COLOR_W  camera pixel, valid one clock after the matching oCam_Req
- oCam_x, oCam_y  out  COORD_W  camera buffer read address
- oCam_Req  out  1  read strobe
- oRed, oGreen, oBlue  out  COLOR_W  composited pixel
- oPix_Valid  out  1  iPix_Valid delayed to align with oRed/oGreen/oBlue
- oCfg_Busy  out  1  a pending geometry set is waiting for frame start
- oFrame_Cnt  out  8  frame counter

Behaviour:
- Reset (synchronous, iRST=1):
  - All outputs 0.
  - Active geometry = DEF_* parameters.
  - Pending set cleared; oCfg_Busy=0; oFrame_Cnt=0; pipeline valid bits 0.
- Configuration:
  - iCfg_Load captures all four iWin_* into the pending set and sets oCfg_Busy.
  - A second load before frame start overwrites the pending set.
  - On iFrame_Start with oCfg_Busy=1: pending set becomes active in the same edge and oCfg_Busy clears.
  - That frame's pixel (0,0) already uses the new geometry.
  - iCfg_Load and iFrame_Start in the same cycle: the new values become pending and apply at the next frame start. Any older pending set is applied now.
- Geometry rules (evaluated when the set becomes active):
  - iWin_W=0 or iWin_H=0 disables the window.
  - Window is clipped to H_ACTIVE/V_ACTIVE: effective W = min(W, H_ACTIVE-X0), and likewise for H.
  - X0 >= H_ACTIVE or Y0 >= V_ACTIVE disables the window.
- Pipeline (3 edges from input to output):
  - Edge 1: register coordinates, iPix_Valid, iVideo_On and the region flags text/window. Window test is X0 <= x < X0+W and Y0 <= y < Y0+H.
  - Edge 2: oCam_x=(x-X0)<<SCALE_SHIFT and oCam_y=(y-Y0)<<SCALE_SHIFT, truncated to COORD_W. oCam_Req=window & iVideo_On & valid; oCam_x/y hold their value when oCam_Req=0.
  - Edge 3: register the colour mux from iRed/iGreen/iBlue and delayed flags.
  - Mux priority: not valid -> BG_COLOR; text -> TEXT_COLOR; window & video_on -> camera pixel; else BG_COLOR.
  - oPix_Valid is iPix_Valid delayed by exactly 3.
- Frame counter:
  - oFrame_Cnt increments on every iFrame_Start and wraps 255 -> 0.
- Pipeline flush:
  - iRST asserted mid-line flushes the pipeline.
  - oPix_Valid is 0 for the 3 cycles following reset release, regardless of input.

Optional Feature:
- Macro: VGA_TEXT_BLINK_EN.
- Defined:
  - A blink toggle flips every BLINK_FRAMES frame starts; it counts its own frames, independent of the oFrame_Cnt wrap.
  - While iVideo_On=0 and the toggle is 0, text pixels output BG_COLOR instead of TEXT_COLOR.
  - With iVideo_On=1 the text band is steady.
  - Toggle resets to 1.
- Undefined: text band is always steady; no blink counter logic exists.

Test Plan:
- Reset, iVideo_On=1, scan (85,75) with iRed=0x155 returned one clock after oCam_Req -> oCam_x=10, oCam_y=10, oRed=0x155, oPix_Valid high 3 clocks after input.
- Scan (5,20) with iVideo_On=1 -> TEXT_COLOR (0x3FF) on all channels; oCam_Req=0. Scan (600,300) -> BG_COLOR (0x000).
- iCfg_Load with X0=0,Y0=100,W=64,H=32 mid-frame -> oCfg_Busy=1; old window still used. At iFrame_Start -> busy clears; (63,131) is camera, (64,131) is BG.
- iCfg_Load and iFrame_Start same cycle, X0=600,W=100 -> not applied this frame; applied next frame with effective W=40; (639,y) camera, clipped region never requests.
- iCfg_Load with W=0 -> after frame start no oCam_Req for a full frame. iPix_Valid=0 -> outputs 0x000 and oPix_Valid=0.
- With VGA_TEXT_BLINK_EN, BLINK_FRAMES=2, iVideo_On=0 -> text band on frames 0-1, off 2-3, on 4-5. 256 frame starts -> oFrame_Cnt returns to 0.

Source files
------------

// File: rtl/vga_window_compositor.sv
// Three-layer VGA compositor: text band over a run-time movable camera window over background.
// Optional text blinking is enabled by defining VGA_TEXT_BLINK_EN.
module vga_window_compositor #(
  parameter int COLOR_W     = 10,
  parameter int COORD_W     = 11,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int TEXT_Y0     = 10,
  parameter int TEXT_HEIGHT = 40,
  parameter int DEF_WIN_X0  = 80,
  parameter int DEF_WIN_Y0  = 70,
  parameter int DEF_WIN_W   = 480,
  parameter int DEF_WIN_H   = 360,
  parameter int SCALE_SHIFT = 1,
  parameter logic [COLOR_W-1:0] TEXT_COLOR = '1,
  parameter logic [COLOR_W-1:0] BG_COLOR   = '0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFrame_Start,
  input  logic               iPix_Valid,
  input  logic [COORD_W-1:0] iVga_x,
  input  logic [COORD_W-1:0] iVga_y,
  input  logic               iVideo_On,
  input  logic [COORD_W-1:0] iWin_X0,
  input  logic [COORD_W-1:0] iWin_Y0,
  input  logic [COORD_W-1:0] iWin_W,
  input  logic [COORD_W-1:0] iWin_H,
  input  logic               iCfg_Load,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [COORD_W-1:0] oCam_x,
  output logic [COORD_W-1:0] oCam_y,
  output logic               oCam_Req,
  output logic [COLOR_W-1:0] oRed,
  output logic [COLOR_W-1:0] oGreen,
  output logic [COLOR_W-1:0] oBlue,
  output logic               oPix_Valid,
  output logic               oCfg_Busy,
  output logic [7:0]         oFrame_Cnt
);

  localparam logic [COORD_W-1:0] H_LIM  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W:0]   TXT_LO = (COORD_W+1)'(TEXT_Y0);
  localparam logic [COORD_W:0]   TXT_HI = (COORD_W+1)'(TEXT_Y0 + TEXT_HEIGHT);

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } geom_t;

  function automatic logic [COORD_W-1:0] clip_len(input logic [COORD_W-1:0] org,
                                                  input logic [COORD_W-1:0] len,
                                                  input logic [COORD_W-1:0] lim);
    if (org >= lim) return '0;
    return (len > lim - org) ? lim - org : len;
  endfunction

  function automatic geom_t resolve(input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0,
                                    input logic [COORD_W-1:0] w,  input logic [COORD_W-1:0] h);
    geom_t g;
    g.en = (w != '0) && (h != '0) && (x0 < H_LIM) && (y0 < V_LIM);
    g.x0 = x0;
    g.y0 = y0;
    g.w  = clip_len(x0, w, H_LIM);
    g.h  = clip_len(y0, h, V_LIM);
    return g;
  endfunction

  function automatic logic [COLOR_W-1:0] pick_color(input logic vld, input logic txt,
                                                    input logic cam, input logic [COLOR_W-1:0] c);
    if (!vld) return BG_COLOR;
    if (txt)  return TEXT_COLOR;
    if (cam)  return c;
    return BG_COLOR;
  endfunction

  geom_t act_geom, pend_geom, use_geom;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      act_geom   <= resolve(COORD_W'(DEF_WIN_X0), COORD_W'(DEF_WIN_Y0),
                            COORD_W'(DEF_WIN_W),  COORD_W'(DEF_WIN_H));
      pend_geom  <= '0;
      oCfg_Busy  <= 1'b0;
      oFrame_Cnt <= '0;
    end else begin
      if (iFrame_Start) oFrame_Cnt <= oFrame_Cnt + 8'd1;
      if (iFrame_Start && oCfg_Busy) act_geom <= pend_geom;
      // A load coinciding with frame start stays pending for the next frame.
      if (iCfg_Load) begin
        pend_geom <= resolve(iWin_X0, iWin_Y0, iWin_W, iWin_H);
        oCfg_Busy <= 1'b1;
      end else if (iFrame_Start) begin
        oCfg_Busy <= 1'b0;
      end
    end
  end

  // Pixel (0,0) of a frame must already see the geometry being swapped in.
  always_comb begin
    use_geom = act_geom;
    if (iFrame_Start && oCfg_Busy) use_geom = pend_geom;
  end

`ifdef VGA_TEXT_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (iFrame_Start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  logic blink_on;
  assign blink_on = 1'b1;
`endif

  logic               text_hit, win_hit;
  logic               vld_p0, txt_p0, win_p0, vid_p0;
  logic [COORD_W-1:0] dx_p0, dy_p0;

  always_comb begin
    text_hit = ({1'b0, iVga_y} >= TXT_LO) && ({1'b0, iVga_y} < TXT_HI);
    win_hit  = use_geom.en &&
               (iVga_x >= use_geom.x0) &&
               ({1'b0, iVga_x} < {1'b0, use_geom.x0} + {1'b0, use_geom.w}) &&
               (iVga_y >= use_geom.y0) &&
               ({1'b0, iVga_y} < {1'b0, use_geom.y0} + {1'b0, use_geom.h});
  end

  // Stage p0: region classification and window-relative offsets
  always_ff @(posedge iCLK) begin
    if (iRST) vld_p0 <= 1'b0;
    else      vld_p0 <= iPix_Valid;
    txt_p0 <= text_hit && (iVideo_On || blink_on);
    win_p0 <= win_hit;
    vid_p0 <= iVideo_On;
    dx_p0  <= iVga_x - use_geom.x0;
    dy_p0  <= iVga_y - use_geom.y0;
  end

  logic cam_req_next;
  logic vld_p1, txt_p1, cam_p1;
  assign cam_req_next = vld_p0 && win_p0 && vid_p0;

  // Stage p1: camera buffer read request
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vld_p1   <= 1'b0;
      oCam_Req <= 1'b0;
      oCam_x   <= '0;
      oCam_y   <= '0;
    end else begin
      vld_p1   <= vld_p0;
      oCam_Req <= cam_req_next;
      if (cam_req_next) begin
        oCam_x <= dx_p0 << SCALE_SHIFT;
        oCam_y <= dy_p0 << SCALE_SHIFT;
      end
    end
    txt_p1 <= txt_p0;
    cam_p1 <= win_p0 && vid_p0;
  end

  // Stage p2: colour mux against the returned camera pixel
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oPix_Valid <= 1'b0;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
    end else begin
      oPix_Valid <= vld_p1;
      oRed       <= pick_color(vld_p1, txt_p1, cam_p1, iRed);
      oGreen     <= pick_color(vld_p1, txt_p1, cam_p1, iGreen);
      oBlue      <= pick_color(vld_p1, txt_p1, cam_p1, iBlue);
    end
  end

endmodule
